// File: rtl/btn_event_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the button event arbiter.
package btn_event_arbiter_pkg;

  localparam int NCH   = 4;
  localparam int IDW   = 2;
  localparam int PTR_W = IDW;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // One-hot mask for a channel index, used to clear the granted pending bit.
  function automatic logic [NCH-1:0] id_to_mask(input logic [IDW-1:0] id);
    return NCH'(1) << id;
  endfunction

endpackage

// File: rtl/btn_event_arbiter_if.sv
// Valid/ready event channel offered by the arbiter to its consumer.
interface btn_event_arbiter_if;
  import btn_event_arbiter_pkg::*;

  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );

endinterface

// File: rtl/btn_event_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_pick
  import btn_event_arbiter_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [PTR_W-1:0] ptr,
  output logic [IDW-1:0]   gnt_id,
  output logic             gnt_any
);

  logic [PTR_W-1:0] idx;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = ptr + PTR_W'(k);
      if (req[idx]) begin
        gnt_id  = idx;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Turns button rising edges into pending requests and offers them one at a time
// on a valid/ready channel in round-robin order, flagging presses that were lost.
module btn_event_arbiter #(
  parameter int NCH = btn_event_arbiter_pkg::NCH,
  parameter int IDW = btn_event_arbiter_pkg::IDW
) (
  input  logic                        slow_clk,
  input  logic                        reset,
  input  logic [NCH-1:0]              btn,
  btn_event_arbiter_if.master         evt,
  output logic [NCH-1:0]              overflow,
  output logic                        busy
);
  import btn_event_arbiter_pkg::state_e;
  import btn_event_arbiter_pkg::IDLE;
  import btn_event_arbiter_pkg::OFFER;
  import btn_event_arbiter_pkg::PTR_W;
  import btn_event_arbiter_pkg::id_to_mask;

  state_e           state_q,    state_d;
  logic [NCH-1:0]   btn_q;
  logic [NCH-1:0]   pending_q,  pending_d;
  logic [NCH-1:0]   overflow_q, overflow_d;
  logic [PTR_W-1:0] ptr_q,      ptr_d;
  logic [IDW-1:0]   evt_id_q,   evt_id_d;
  logic             busy_q,     busy_d;

  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   clr;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_any;
  logic             load;

  assign rise = btn & ~btn_q;

  rr_pick u_rr_pick (
    .req     (pending_q),
    .ptr     (ptr_q),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge slow_clk) begin
    if (reset) begin
      // Capturing btn here means a button held through reset is not seen as a new press.
      btn_q      <= btn;
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= '0;
      ptr_q      <= '0;
      evt_id_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      btn_q      <= btn;
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      ptr_q      <= ptr_d;
      evt_id_q   <= evt_id_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    evt_id_d = evt_id_q;
    load     = 1'b0;
    clr      = '0;

    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          load    = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (evt.evt_ready) begin
          if (gnt_any) load = 1'b1;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      clr      = id_to_mask(gnt_id);
      evt_id_d = gnt_id;
      ptr_d    = gnt_id + PTR_W'(1);
    end

    // A rise coinciding with its own grant re-arms the channel; only a rise on a
    // still-pending channel counts as a lost press.
    pending_d  = (pending_q & ~clr) | rise;
    overflow_d = overflow_q | (rise & pending_q & ~clr);
    busy_d     = (state_d == OFFER) | (|pending_d);
  end

  assign evt.evt_valid = (state_q == OFFER);
  assign evt.evt_id    = evt_id_q;
  assign overflow      = overflow_q;
  assign busy          = busy_q;

  a_id_stable_on_stall : assert property (@(posedge slow_clk)
    (evt.evt_valid && !evt.evt_ready && !reset) |=> $stable(evt.evt_id));

  a_overflow_sticky : assert property (@(posedge slow_clk)
    (!reset) |=> ((overflow_q & $past(overflow_q)) == $past(overflow_q)));

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: single press, simultaneous presses,
// wrap-around, overflow, stall, reset behaviour and the set-wins corner.
module tb_btn_event_arbiter;
  import btn_event_arbiter_pkg::*;

  logic           slow_clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] btn;
  logic [NCH-1:0] overflow;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;

  btn_event_arbiter_if evt_if ();

  btn_event_arbiter #(.NCH(4), .IDW(2)) dut (
    .slow_clk (slow_clk),
    .reset    (reset),
    .btn      (btn),
    .evt      (evt_if.master),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 slow_clk = ~slow_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it before sampling or driving.
  task automatic step();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic check_evt(input string tag, input logic v, input logic [IDW-1:0] id);
    check({tag, ".valid"}, 32'(evt_if.evt_valid), 32'(v));
    if (v) check({tag, ".id"}, 32'(evt_if.evt_id), 32'(id));
  endtask

  initial begin
    reset = 1'b1;
    btn   = '0;
    evt_if.evt_ready = 1'b0;
    step();
    step();
    check("rst.valid", 32'(evt_if.evt_valid), 32'd0);
    check("rst.id",    32'(evt_if.evt_id),    32'd0);
    check("rst.busy",  32'(busy),             32'd0);
    check("rst.ovf",   32'(overflow),         32'd0);

    // Single press: offered one edge after the rise, gone after acceptance.
    reset = 1'b0;
    btn   = 4'b0001;
    step();
    check_evt("single.rise", 1'b0, 2'd0);
    check("single.rise.busy", 32'(busy), 32'd1);
    step();
    check_evt("single.offer", 1'b1, 2'd0);
    evt_if.evt_ready = 1'b1;
    step();
    check_evt("single.acc", 1'b0, 2'd0);
    check("single.acc.busy", 32'(busy), 32'd0);
    evt_if.evt_ready = 1'b0;
    btn = '0;
    step();

    // Simultaneous presses from ptr=0 with ready tied high: 0,1,3 back to back.
    reset = 1'b1;
    step();
    reset = 1'b0;
    btn   = 4'b1011;
    evt_if.evt_ready = 1'b1;
    step();
    check_evt("simul.rise", 1'b0, 2'd0);
    step();
    check_evt("simul.e0", 1'b1, 2'd0);
    step();
    check_evt("simul.e1", 1'b1, 2'd1);
    step();
    check_evt("simul.e2", 1'b1, 2'd3);
    step();
    check_evt("simul.end", 1'b0, 2'd0);
    check("simul.busy", 32'(busy), 32'd0);
    btn = '0;
    evt_if.evt_ready = 1'b0;
    step();

    // Wrap-around: granting channel 2 moves ptr to 3, then pending 1001 serves 3 then 0.
    btn = 4'b0100;
    step();
    step();
    check_evt("wrap.e2", 1'b1, 2'd2);
    btn = 4'b1001;
    step();
    check_evt("wrap.hold", 1'b1, 2'd2);
    evt_if.evt_ready = 1'b1;
    step();
    check_evt("wrap.e3", 1'b1, 2'd3);
    step();
    check_evt("wrap.e0", 1'b1, 2'd0);
    step();
    check_evt("wrap.end", 1'b0, 2'd0);
    btn = '0;
    evt_if.evt_ready = 1'b0;
    step();

    // Overflow: channel 2 pressed twice while channel 0 is held on the output.
    btn = 4'b0001;
    step();
    step();
    check_evt("ovf.e0", 1'b1, 2'd0);
    btn = 4'b0101;
    step();
    check("ovf.first", 32'(overflow), 32'd0);
    btn = 4'b0001;
    step();
    btn = 4'b0101;
    step();
    check("ovf.second", 32'(overflow), 32'b0100);
    for (int i = 0; i < 10; i++) begin
      step();
      check_evt($sformatf("stall%0d", i), 1'b1, 2'd0);
    end
    evt_if.evt_ready = 1'b1;
    step();
    check_evt("ovf.e2", 1'b1, 2'd2);
    step();
    check_evt("ovf.end", 1'b0, 2'd0);
    check("ovf.busy", 32'(busy), 32'd0);
    evt_if.evt_ready = 1'b0;
    btn = '0;
    step();
    check("ovf.sticky", 32'(overflow), 32'b0100);

    // Reset with all buttons held: no events afterwards, overflow cleared.
    reset = 1'b1;
    btn   = 4'b1111;
    step();
    check("hold.ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_evt($sformatf("hold%0d", i), 1'b0, 2'd0);
      check($sformatf("hold%0d.busy", i), 32'(busy), 32'd0);
    end

    // Set wins: channel 1 rises in the same edge its pending bit is granted.
    btn = '0;
    step();
    btn = 4'b0001;
    step();
    step();
    check_evt("setwin.e0", 1'b1, 2'd0);
    btn = 4'b0011;
    step();
    btn = 4'b0001;
    step();
    btn = 4'b0011;
    evt_if.evt_ready = 1'b1;
    step();
    check_evt("setwin.e1a", 1'b1, 2'd1);
    check("setwin.ovf", 32'(overflow), 32'd0);
    step();
    check_evt("setwin.e1b", 1'b1, 2'd1);
    step();
    check_evt("setwin.end", 1'b0, 2'd0);
    check("setwin.busy", 32'(busy), 32'd0);
    evt_if.evt_ready = 1'b0;
    btn = '0;
    step();

    // Reset mid-offer drops the offered event and the pending one.
    btn = 4'b1000;
    step();
    step();
    check_evt("rstoff.e3", 1'b1, 2'd3);
    btn = 4'b1100;
    step();
    reset = 1'b1;
    step();
    check_evt("rstoff.rst", 1'b0, 2'd0);
    check("rstoff.id", 32'(evt_if.evt_id), 32'd0);
    check("rstoff.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();
    step();
    check_evt("rstoff.after", 1'b0, 2'd0);
    check("rstoff.after.busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
